// File: rtl/spi_slave_multi_if.sv
// spi_slave_multi_if
//   Bundles the per-channel SPI pins and the receive-side status of
//   spi_slave_multi.
//   sck, ssel, mosi  : SPI pins from the master, one bit per channel
//   miso             : SPI data back to the master, one bit per channel
//   tx_data          : word returned to the master, channel c = [c*DW +: DW]
//   rx_data          : last good received word per channel, held
//   rx_valid, rx_err : one-cycle strobes for a good or rejected frame
//   busy             : channel is inside a frame
//   frame_cnt        : good-frame counters, 16 bits per channel, wrapping
//   err_cnt          : rejected-frame counters, 16 bits per channel, saturating
interface spi_slave_multi_if #(
    parameter int NCH = 2,
    parameter int DW  = 32
);
    logic [NCH-1:0]    sck;
    logic [NCH-1:0]    ssel;
    logic [NCH-1:0]    mosi;
    logic [NCH-1:0]    miso;
    logic [NCH*DW-1:0] tx_data;
    logic [NCH*DW-1:0] rx_data;
    logic [NCH-1:0]    rx_valid;
    logic [NCH-1:0]    rx_err;
    logic [NCH-1:0]    busy;
    logic [NCH*16-1:0] frame_cnt;
    logic [NCH*16-1:0] err_cnt;

    modport slave (
        input  sck, ssel, mosi, tx_data,
        output miso, rx_data, rx_valid, rx_err, busy, frame_cnt, err_cnt
    );

    modport master (
        output sck, ssel, mosi, tx_data,
        input  miso, rx_data, rx_valid, rx_err, busy, frame_cnt, err_cnt
    );
endinterface

// File: rtl/spi_slave_multi.sv
// spi_slave_multi
//   NCH independent mode-0 SPI slaves. All SPI pins are oversampled in the
//   clk domain; each channel checks frame length and SCK inactivity, and
//   publishes good DW-bit words (MSB first) as held data with a one-cycle
//   valid strobe. Malformed or timed-out frames only raise rx_err.
//   clk   : system clock, all logic on posedge
//   reset : synchronous, active low
//   bus   : spi_slave_multi_if slave modport (pins, tx/rx words, status)
module spi_slave_multi #(
    parameter int NCH     = 2,
    parameter int DW      = 32,
    parameter int SYNC    = 3,
    parameter int TIMEOUT = 1024
) (
    input logic              clk,
    input logic              reset,
    spi_slave_multi_if.slave bus
);

    localparam int BW = $clog2(DW + 2);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] BIT_FULL = BW'(DW);
    localparam logic [BW-1:0] BIT_SAT  = BW'(DW + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] WAIT_HI = 2'd0;
    localparam logic [1:0] IDLE    = 2'd1;
    localparam logic [1:0] ACTIVE  = 2'd2;

    logic [SYNC-1:0]         sck_s  [NCH];
    logic [SYNC-1:0]         ssel_s [NCH];
    logic [SYNC-1:0]         mosi_s [NCH];
    logic [1:0]              state  [NCH];
    logic [DW-1:0]           rx_shift [NCH];
    logic [DW-1:0]           tx_shift [NCH];
    logic [BW-1:0]           bit_cnt  [NCH];
    logic [TW-1:0]           tmo      [NCH];
    logic [NCH-1:0][DW-1:0]  rx_data_q;
    logic [NCH-1:0][15:0]    fcnt;
    logic [NCH-1:0][15:0]    ecnt;
    logic [NCH-1:0]          miso_q;
    logic [NCH-1:0]          rx_valid_q;
    logic [NCH-1:0]          rx_err_q;
    logic [NCH-1:0]          busy_q;

    logic [NCH-1:0] sck_rise, sck_fall, ssel_rise, ssel_fall, ssel_now, mosi_now;

    // Edges compare the two oldest synchroniser stages; the newer of the
    // two is the current synchronised level.
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            sck_rise[c]  =  sck_s[c][SYNC-2]  & ~sck_s[c][SYNC-1];
            sck_fall[c]  = ~sck_s[c][SYNC-2]  &  sck_s[c][SYNC-1];
            ssel_rise[c] =  ssel_s[c][SYNC-2] & ~ssel_s[c][SYNC-1];
            ssel_fall[c] = ~ssel_s[c][SYNC-2] &  ssel_s[c][SYNC-1];
            ssel_now[c]  =  ssel_s[c][SYNC-2];
            mosi_now[c]  =  mosi_s[c][SYNC-2];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                sck_s[c]    <= '0;
                ssel_s[c]   <= '0;
                mosi_s[c]   <= '0;
                state[c]    <= WAIT_HI;
                rx_shift[c] <= '0;
                tx_shift[c] <= '0;
                bit_cnt[c]  <= '0;
                tmo[c]      <= '0;
            end
            rx_data_q  <= '0;
            fcnt       <= '0;
            ecnt       <= '0;
            miso_q     <= '0;
            rx_valid_q <= '0;
            rx_err_q   <= '0;
            busy_q     <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                sck_s[c]  <= {sck_s[c][SYNC-2:0],  bus.sck[c]};
                ssel_s[c] <= {ssel_s[c][SYNC-2:0], bus.ssel[c]};
                mosi_s[c] <= {mosi_s[c][SYNC-2:0], bus.mosi[c]};
                rx_valid_q[c] <= 1'b0;
                rx_err_q[c]   <= 1'b0;

                case (state[c])
                    WAIT_HI: begin
                        miso_q[c] <= 1'b0;
                        busy_q[c] <= 1'b0;
                        if (ssel_now[c]) state[c] <= IDLE;
                    end

                    IDLE: begin
                        miso_q[c] <= 1'b0;
                        busy_q[c] <= 1'b0;
                        if (ssel_fall[c]) begin
                            tx_shift[c] <= bus.tx_data[c*DW +: DW];
                            miso_q[c]   <= bus.tx_data[c*DW + DW - 1];
                            bit_cnt[c]  <= '0;
                            tmo[c]      <= '0;
                            busy_q[c]   <= 1'b1;
                            state[c]    <= ACTIVE;
                        end
                    end

                    ACTIVE: begin
                        // Priority: ssel rise, then sck edges, then timeout.
                        if (ssel_rise[c]) begin
                            miso_q[c] <= 1'b0;
                            busy_q[c] <= 1'b0;
                            state[c]  <= IDLE;
                            if (bit_cnt[c] == BIT_FULL) begin
                                rx_data_q[c]  <= rx_shift[c];
                                rx_valid_q[c] <= 1'b1;
                                fcnt[c]       <= fcnt[c] + 16'd1;
                            end else begin
                                rx_err_q[c] <= 1'b1;
                                if (ecnt[c] != 16'hFFFF) ecnt[c] <= ecnt[c] + 16'd1;
                            end
                        end else if (sck_rise[c]) begin
                            rx_shift[c] <= {rx_shift[c][DW-2:0], mosi_now[c]};
                            if (bit_cnt[c] != BIT_SAT) bit_cnt[c] <= bit_cnt[c] + 1'b1;
                            tmo[c] <= '0;
                        end else if (sck_fall[c]) begin
                            // Zeros shift in behind the word, so miso idles
                            // low once the last bit has gone out.
                            tx_shift[c] <= {tx_shift[c][DW-2:0], 1'b0};
                            miso_q[c]   <= tx_shift[c][DW-2];
                            tmo[c]      <= '0;
                        end else if (tmo[c] == TMO_LAST) begin
                            rx_err_q[c] <= 1'b1;
                            if (ecnt[c] != 16'hFFFF) ecnt[c] <= ecnt[c] + 16'd1;
                            miso_q[c] <= 1'b0;
                            busy_q[c] <= 1'b0;
                            state[c]  <= WAIT_HI;
                        end else begin
                            tmo[c] <= tmo[c] + 1'b1;
                        end
                    end

                    default: begin
                        miso_q[c] <= 1'b0;
                        busy_q[c] <= 1'b0;
                        state[c]  <= WAIT_HI;
                    end
                endcase
            end
        end
    end

    assign bus.miso      = miso_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_err    = rx_err_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = fcnt;
    assign bus.err_cnt   = ecnt;

endmodule
